// File: rtl/pulser_bank.sv
// pulser_bank: per-channel 2-flop synchronizer, debounce FSM and edge pulser.
// Defining PULSER_AUTOREPEAT_EN adds auto-repeat pulses while a channel is held.
module pulser_bank #(
  parameter int N_CH          = 4,
  parameter int DEB_CYCLES    = 16,
  parameter int CNT_W         = 16,
  parameter int EDGE_MODE     = 0,
  parameter int REPEAT_DELAY  = 1000,
  parameter int REPEAT_PERIOD = 200
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] btn_i,
  input  logic [N_CH-1:0] mask_i,
  output logic [N_CH-1:0] pulse_o,
  output logic [N_CH-1:0] level_o,
  output logic            any_pulse_o
);

  // state | meaning: REL stable 0 | PRESS_WAIT qualifying 0->1 | HELD stable 1 | REL_WAIT qualifying 1->0
  typedef enum logic [1:0] {REL, PRESS_WAIT, HELD, REL_WAIT} state_t;

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam bit               PRESS_EN = (EDGE_MODE != 1);
  localparam bit               REL_EN   = (EDGE_MODE != 0);

  logic [N_CH-1:0]  s1, s2;
  state_t           state_q [N_CH];
  state_t           state_d [N_CH];
  logic [CNT_W-1:0] cnt_q [N_CH];
  logic [CNT_W-1:0] cnt_d [N_CH];
  logic [N_CH-1:0]  level_d, event_d, rep_d, pulse_d;

  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      level_d[i] = level_o[i];
      event_d[i] = 1'b0;
      case (state_q[i])
        REL: if (s2[i]) begin
          // A one-cycle debounce accepts the level on the very first sample.
          if (DEB_LAST == '0) begin
            state_d[i] = HELD;
            level_d[i] = 1'b1;
            event_d[i] = PRESS_EN;
          end else begin
            state_d[i] = PRESS_WAIT;
            cnt_d[i]   = CNT_W'(1);
          end
        end
        PRESS_WAIT: begin
          if (!s2[i]) begin
            state_d[i] = REL;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] >= DEB_LAST) begin
            state_d[i] = HELD;
            cnt_d[i]   = '0;
            level_d[i] = 1'b1;
            event_d[i] = PRESS_EN;
          end else if (cnt_q[i] != CNT_MAX) begin
            cnt_d[i] = cnt_q[i] + 1'b1;
          end
        end
        HELD: if (!s2[i]) begin
          if (DEB_LAST == '0) begin
            state_d[i] = REL;
            level_d[i] = 1'b0;
            event_d[i] = REL_EN;
          end else begin
            state_d[i] = REL_WAIT;
            cnt_d[i]   = CNT_W'(1);
          end
        end
        REL_WAIT: begin
          if (s2[i]) begin
            state_d[i] = HELD;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] >= DEB_LAST) begin
            state_d[i] = REL;
            cnt_d[i]   = '0;
            level_d[i] = 1'b0;
            event_d[i] = REL_EN;
          end else if (cnt_q[i] != CNT_MAX) begin
            cnt_d[i] = cnt_q[i] + 1'b1;
          end
        end
        default: begin
          state_d[i] = REL;
          cnt_d[i]   = '0;
        end
      endcase
    end
  end

`ifdef PULSER_AUTOREPEAT_EN
  localparam logic [CNT_W-1:0] REP_DLY_LD = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] REP_PER_LD = CNT_W'(REPEAT_PERIOD - 1);

  logic [CNT_W-1:0] rcnt_q [N_CH];
  logic [CNT_W-1:0] rcnt_d [N_CH];

  // Down-counter per channel; any entry into HELD (press or bounce-back) restarts the delay.
  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      rcnt_d[i] = '0;
      rep_d[i]  = 1'b0;
      if (state_d[i] == HELD) begin
        if (state_q[i] != HELD) begin
          rcnt_d[i] = REP_DLY_LD;
        end else if (rcnt_q[i] == '0) begin
          rcnt_d[i] = REP_PER_LD;
          rep_d[i]  = PRESS_EN;
        end else begin
          rcnt_d[i] = rcnt_q[i] - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) rcnt_q <= '{default: '0};
    else     rcnt_q <= rcnt_d;
  end
`else
  logic unused_repeat_cfg;
  assign unused_repeat_cfg = (REPEAT_DELAY > 0) ^ (REPEAT_PERIOD > 0);
  assign rep_d = '0;
`endif

  assign pulse_d = (event_d | rep_d) & ~mask_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1          <= '0;
      s2          <= '0;
      pulse_o     <= '0;
      level_o     <= '0;
      any_pulse_o <= 1'b0;
      for (int i = 0; i < N_CH; i++) begin
        state_q[i] <= REL;
        cnt_q[i]   <= '0;
      end
    end else begin
      s1          <= btn_i;
      s2          <= s1;
      pulse_o     <= pulse_d;
      level_o     <= level_d;
      any_pulse_o <= |pulse_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
    end
  end

endmodule

// File: tb/tb_pulser_bank.sv
// tb_pulser_bank: vector table, multi-cycle corner sequences and randomized
// stimulus compared every cycle against a run-length model of the debounce rules.
module tb_pulser_bank;
  localparam int N     = 4;
  localparam int DEB   = 4;
  localparam int DLY_A = 10;
  localparam int PER_A = 5;
  localparam int DLY_B = 100;
  localparam int PER_B = 50;
`ifdef PULSER_AUTOREPEAT_EN
  localparam bit REPEAT_ON = 1'b1;
`else
  localparam bit REPEAT_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N-1:0] btn = '0;
  logic [N-1:0] mask = '0;
  logic [N-1:0] pulse_a, level_a, pulse_b, level_b;
  logic any_a, any_b;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pulser_bank #(.N_CH(N), .DEB_CYCLES(DEB), .CNT_W(16), .EDGE_MODE(0),
                .REPEAT_DELAY(DLY_A), .REPEAT_PERIOD(PER_A)) u_dut_a (
    .clk(clk), .rst(rst), .btn_i(btn), .mask_i(mask),
    .pulse_o(pulse_a), .level_o(level_a), .any_pulse_o(any_a));

  pulser_bank #(.N_CH(N), .DEB_CYCLES(DEB), .CNT_W(16), .EDGE_MODE(2),
                .REPEAT_DELAY(DLY_B), .REPEAT_PERIOD(PER_B)) u_dut_b (
    .clk(clk), .rst(rst), .btn_i(btn), .mask_i(mask),
    .pulse_o(pulse_b), .level_o(level_b), .any_pulse_o(any_b));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a level flips once the synchronized input has differed
  // from it for DEB consecutive samples; repeats count edges since entering hold.
  int mode_of [2] = '{0, 2};
  int dly_of  [2] = '{DLY_A, DLY_B};
  int per_of  [2] = '{PER_A, PER_B};
  logic [N-1:0] m_s1 = '0, m_s2 = '0;
  logic [N-1:0] m_lvl [2];
  logic [N-1:0] exp_pulse [2];
  int m_rl  [2][N];
  int m_age [2][N];

  always @(posedge clk) begin
    logic ev, rep;
    if (rst) begin
      m_s1 = '0;
      m_s2 = '0;
      for (int d = 0; d < 2; d++) begin
        m_lvl[d] = '0;
        exp_pulse[d] = '0;
        for (int c = 0; c < N; c++) begin
          m_rl[d][c] = 0;
          m_age[d][c] = 0;
        end
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        exp_pulse[d] = '0;
        for (int c = 0; c < N; c++) begin
          ev = 1'b0;
          rep = 1'b0;
          if (m_s2[c] != m_lvl[d][c]) begin
            m_rl[d][c]++;
            if (m_rl[d][c] >= DEB) begin
              m_lvl[d][c] = m_s2[c];
              m_rl[d][c] = 0;
              m_age[d][c] = 0;
              ev = m_s2[c] ? (mode_of[d] != 1) : (mode_of[d] != 0);
            end
          end else begin
            if (m_lvl[d][c] && m_rl[d][c] > 0) begin
              m_age[d][c] = 0;
            end else if (m_lvl[d][c]) begin
              m_age[d][c]++;
              if (REPEAT_ON && mode_of[d] != 1 &&
                  (m_age[d][c] == dly_of[d] ||
                   (m_age[d][c] > dly_of[d] && (m_age[d][c] - dly_of[d]) % per_of[d] == 0)))
                rep = 1'b1;
            end
            m_rl[d][c] = 0;
          end
          exp_pulse[d][c] = (ev | rep) & ~mask[c];
        end
      end
      m_s2 = m_s1;
      m_s1 = btn;
    end
  end

  always @(negedge clk) begin
    check("sb_pulse_a", pulse_a, exp_pulse[0]);
    check("sb_level_a", level_a, m_lvl[0]);
    check("sb_any_a",   any_a,   |exp_pulse[0]);
    check("sb_pulse_b", pulse_b, exp_pulse[1]);
    check("sb_level_b", level_b, m_lvl[1]);
    check("sb_any_b",   any_b,   |exp_pulse[1]);
  end

  typedef struct {
    logic         rst;
    logic [N-1:0] btn;
    logic [N-1:0] mask;
    int           ncyc;
    logic [N-1:0] lvl;
    logic [N-1:0] pls;
    logic         any;
  } vec_t;

  vec_t tbl [13];
  int   hits [$];
  int   exp_q [$];
  logic [N-1:0] tgt;

  initial begin
    tbl[0]  = '{1'b1, 4'b0000, 4'b0000, 2,  4'b0000, 4'b0000, 1'b0};
    tbl[1]  = '{1'b0, 4'b0001, 4'b0000, 5,  4'b0000, 4'b0000, 1'b0};
    tbl[2]  = '{1'b0, 4'b0001, 4'b0000, 1,  4'b0001, 4'b0001, 1'b1};
    tbl[3]  = '{1'b0, 4'b0001, 4'b0000, 1,  4'b0001, 4'b0000, 1'b0};
    tbl[4]  = '{1'b0, 4'b1001, 4'b1000, 5,  4'b0001, 4'b0000, 1'b0};
    tbl[5]  = '{1'b0, 4'b1001, 4'b1000, 1,  4'b1001, 4'b0000, 1'b0};
    tbl[6]  = '{1'b0, 4'b1001, 4'b1000, 1,  4'b1001, 4'b0000, 1'b0};
    tbl[7]  = '{1'b0, 4'b0000, 4'b0000, 5,  4'b1001, 4'b0000, 1'b0};
    tbl[8]  = '{1'b0, 4'b0000, 4'b0000, 1,  4'b0000, 4'b0000, 1'b0};
    tbl[9]  = '{1'b0, 4'b0000, 4'b0000, 3,  4'b0000, 4'b0000, 1'b0};
    tbl[10] = '{1'b0, 4'b1001, 4'b1000, 5,  4'b0000, 4'b0000, 1'b0};
    tbl[11] = '{1'b0, 4'b1001, 4'b1000, 1,  4'b1001, 4'b0001, 1'b1};
    tbl[12] = '{1'b0, 4'b0000, 4'b0000, 10, 4'b0000, 4'b0000, 1'b0};

    @(negedge clk);
    for (int r = 0; r < 13; r++) begin
      rst  = tbl[r].rst;
      btn  = tbl[r].btn;
      mask = tbl[r].mask;
      repeat (tbl[r].ncyc) @(negedge clk);
      check($sformatf("tbl%0d_level", r), level_a, tbl[r].lvl);
      check($sformatf("tbl%0d_pulse", r), pulse_a, tbl[r].pls);
      check($sformatf("tbl%0d_any", r),   any_a,   tbl[r].any);
    end

    // Bounce on ch1: alternate-cycle toggling never qualifies.
    for (int t = 0; t < 16; t++) begin
      btn[1] = (t < 4) ? ((t % 2) == 0) : 1'b0;
      @(negedge clk);
      check("bounce_pulse1", pulse_a[1], 1'b0);
      check("bounce_level1", level_a[1], 1'b0);
    end

    // Both-edge instance: 20-cycle press on ch2 gives press and release pulses.
    hits.delete();
    for (int t = 0; t < 40; t++) begin
      btn[2] = (t < 20);
      @(negedge clk);
      if (pulse_b[2]) hits.push_back(t);
    end
    check("edge2_count", hits.size(), 2);
    check("edge2_press_at",   (hits.size() > 0) ? hits[0] : -1, 5);
    check("edge2_release_at", (hits.size() > 1) ? hits[1] : -1, 25);

    // Reset while ch0 is held, then a fresh debounce and single pulse.
    btn = '0;
    repeat (8) @(negedge clk);
    btn[0] = 1'b1;
    repeat (8) @(negedge clk);
    check("hold_level0", level_a[0], 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_level_a", level_a, '0);
    check("rst_pulse_a", pulse_a, '0);
    check("rst_any_a",   any_a,   1'b0);
    check("rst_level_b", level_b, '0);
    hits.delete();
    for (int t = 0; t < 8; t++) begin
      @(negedge clk);
      if (pulse_a[0]) hits.push_back(t);
    end
    check("rst_fresh_count", hits.size(), 1);
    check("rst_fresh_at", (hits.size() > 0) ? hits[0] : -1, 5);

    // Long hold on ch0: one pulse, or the auto-repeat train when enabled.
    btn = '0;
    repeat (8) @(negedge clk);
    btn[0] = 1'b1;
    hits.delete();
    for (int t = 0; t < 47; t++) begin
      @(negedge clk);
      if (pulse_a[0]) hits.push_back(t);
    end
    btn = '0;
    exp_q = {5};
    if (REPEAT_ON) for (int p = 5 + DLY_A; p <= 45; p += PER_A) exp_q.push_back(p);
    check("hold_pulse_count", hits.size(), exp_q.size());
    for (int j = 0; j < exp_q.size(); j++)
      check($sformatf("hold_pulse%0d_at", j), (j < hits.size()) ? hits[j] : -1, exp_q[j]);
    repeat (8) @(negedge clk);

    // Randomized traffic: fast then slow target changes, glitches, masks, rare resets.
    tgt = '0;
    for (int ph = 0; ph < 2; ph++) begin
      for (int t = 0; t < 3000; t++) begin
        for (int c = 0; c < N; c++)
          if ($urandom_range(0, (ph == 0) ? 15 : 63) == 0) tgt[c] = ~tgt[c];
        btn = tgt;
        for (int c = 0; c < N; c++)
          if ($urandom_range(0, 9) == 0) btn[c] = ~tgt[c];
        if ($urandom_range(0, 63) == 0) mask = N'($urandom);
        rst = ($urandom_range(0, 499) == 0);
        @(negedge clk);
      end
    end
    rst = 1'b0;
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pulser_bank.md
PULSER_BANK -- requirements
Module: pulser_bank

Interface
REQ-001 SHALL have parameter N_CH, default 4: number of independent input channels, 1..32.
REQ-002 SHALL have parameter DEB_CYCLES, default 16: consecutive stable cycles needed to accept a level change, 1..2^CNT_W-1.
REQ-003 SHALL have parameter CNT_W, default 16: width of the per-channel debounce and repeat counters.
REQ-004 SHALL have parameter EDGE_MODE, default 0: 0 pulses on press (0->1), 1 on release (1->0), 2 on both.
REQ-005 SHALL have parameter REPEAT_DELAY, default 1000: cycles from the press pulse to the first repeat pulse (used only under PULSER_AUTOREPEAT_EN).
REQ-006 SHALL have parameter REPEAT_PERIOD, default 200: cycles between successive repeat pulses (used only under PULSER_AUTOREPEAT_EN).
REQ-007 SHALL have port clk, input, 1 bit: single clock; all flops on posedge.
REQ-008 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-009 SHALL have port btn_i, input, N_CH bits: raw asynchronous push-button levels.
REQ-010 SHALL have port mask_i, input, N_CH bits: 1 suppresses pulse_o for that channel; level tracking continues.
REQ-011 SHALL have port pulse_o, output, N_CH bits: registered one-cycle event pulse per channel.
REQ-012 SHALL have port level_o, output, N_CH bits: registered debounced level per channel.
REQ-013 SHALL have port any_pulse_o, output, 1 bit: registered OR of pulse_o.

Function
REQ-014 SHALL pass each btn_i bit through a 2-flop synchronizer (s1 then s2) before any other use.
REQ-015 SHALL run one 4-state FSM per channel: REL (stable 0), PRESS_WAIT, HELD (stable 1), REL_WAIT.
REQ-016 In REL, s2=1 SHALL move the FSM to PRESS_WAIT with the counter set to 1; in HELD, s2=0 SHALL move it to REL_WAIT with the counter set to 1.
REQ-017 In a WAIT state, s2 equal to the target level SHALL increment the counter; reaching DEB_CYCLES SHALL enter the target state and update level_o on the same edge.
REQ-018 In a WAIT state, s2 reverting (bounce) SHALL return the FSM to its previous stable state, clear the counter, and produce no pulse.
REQ-019 A stable-state change matching EDGE_MODE SHALL assert pulse_o for exactly one cycle, on the same edge as the level_o update, unless mask_i is 1 on that edge.
REQ-020 Latency: with btn_i steady from the first edge k that samples it, level_o and pulse_o SHALL change at edge k+DEB_CYCLES+1.
REQ-021 Channels SHALL be fully independent; simultaneous events SHALL pulse every qualifying channel in the same cycle.
REQ-022 any_pulse_o SHALL equal OR(pulse_o) in the same cycle, both registered.
REQ-023 A held level SHALL never generate more than one debounce pulse, regardless of hold duration.
REQ-024 Counters SHALL saturate and never wrap.

Reset
REQ-025 While rst=1 at an edge, every FSM SHALL go to REL, all counters and synchronizer flops to 0, and pulse_o, level_o, any_pulse_o to 0.
REQ-026 Reset asserted during PRESS_WAIT or HELD SHALL discard the pending or held state; a button still held after reset SHALL be debounced afresh and pulse once.

Configuration
REQ-027 With PULSER_AUTOREPEAT_EN defined, a channel in HELD with EDGE_MODE 0 or 2 SHALL pulse REPEAT_DELAY cycles after its press pulse, then every REPEAT_PERIOD cycles, until it leaves HELD.
REQ-028 Repeat pulses SHALL obey mask_i; leaving HELD or reset SHALL clear the repeat counter.
REQ-029 Without PULSER_AUTOREPEAT_EN, no repeat logic SHALL be present, REPEAT_* SHALL be ignored, and REQ-023 SHALL hold.

Verification
REQ-030 DEB_CYCLES=4, EDGE_MODE=0; btn_i[0] rises before edge 10 and stays high -> pulse_o[0]=1 only after edge 15, level_o[0]=1 thereafter, any_pulse_o=1 on the same cycle.
REQ-031 btn_i[1] toggles 1,0,1,0 on alternate cycles, then stays 0 -> pulse_o[1] and level_o[1] stay 0 throughout.
REQ-032 EDGE_MODE=2; 20-cycle press on ch2 -> exactly 2 pulses, one at the press and one at the release, each DEB_CYCLES+1 edges after its edge.
REQ-033 mask_i[3]=1; ch3 pressed -> level_o[3]=1 and pulse_o[3] stays 0; ch0 pressed in the same cycle -> pulse_o[0]=1.
REQ-034 rst=1 for one cycle while ch0 is held in HELD -> all outputs 0 next cycle, then one fresh pulse after DEB_CYCLES+1 edges.
REQ-035 PULSER_AUTOREPEAT_EN, REPEAT_DELAY=10, REPEAT_PERIOD=5; hold ch0 for 40 cycles after the press pulse -> pulses at +0, +10, +15, +20, +25, +30, +35, +40.
